uc_eng_port: RTL and testbench
==============================

UC_ENG_PORT -- requirements
Module: uc_eng_port

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 resets all state immediately.
REQ-003 uca2eng  input  LIT_W signed  broadcast unit-clause literal from the arbiter queue; two's complement; sign = polarity.
REQ-004 uca2eng_valid  input  1  uca2eng holds a valid literal this cycle (arbiter pop).
REQ-005 uca2eng_full  output  1  inbound FIFO is full; the arbiter holds its pops while any engine asserts full.
REQ-006 eng2uca  output  LIT_W signed  head of the outbound FIFO; 0 when the FIFO is empty.
REQ-007 eng2uca_valid  output  1  equals !eng2uca_empty.
REQ-008 eng2uca_empty  output  1  outbound FIFO is empty.
REQ-009 uca_grant  input  1  arbiter consumed eng2uca this cycle (engmask bit selected and PROC state).
REQ-010 conflict  input  1  global conflict from the arbiter.
REQ-011 bcp_uc_valid / bcp_uc (LIT_W) / bcp_uc_ready  in/in/out  engine-discovered UC handshake.
REQ-012 uc_out_valid / uc_out (LIT_W) / uc_out_ready  out/out/in  received UC delivered to the engine BCP.
REQ-013 drop_cnt  output  8  saturating count of outbound UCs suppressed as duplicates.
REQ-014 ovf_err  output  1  sticky flag: broadcast arrived while inbound FIFO full.

Function
REQ-015 States RUN and HALT; reset enters RUN; conflict=1 in RUN moves to HALT next cycle; HALT exits only on reset.
REQ-016 Inbound FIFO depth IN_DEPTH=4; push when uca2eng_valid && uca2eng!=0 && !full && state==RUN.
REQ-017 uca2eng_valid while full: literal discarded, ovf_err set next cycle, FIFO unchanged.
REQ-018 uca2eng_full = (in_count==IN_DEPTH), registered count, no combinational path from uca2eng_valid.
REQ-019 uc_out/uc_out_valid present the inbound head; pop when uc_out_valid && uc_out_ready; push+pop in the same cycle leaves the count unchanged.
REQ-020 Seen table: LIT_IDX_MAX x 2 bits indexed [abs(lit)][sign]; set on every accepted broadcast; visible from the next cycle.
REQ-021 Outbound FIFO depth OUT_DEPTH=4; bcp_uc_ready = !out_full && state==RUN.
REQ-022 Accepted bcp_uc with seen[abs][sign]=1, or equal to a same-cycle accepted broadcast (bypass compare), is dropped and drop_cnt increments (saturates at 255); otherwise it is enqueued.
REQ-023 The opposite-polarity literal of a seen entry is still enqueued; the arbiter detects the conflict.
REQ-024 bcp_uc==0 is ignored: not enqueued and not counted.
REQ-025 uca_grant && !empty pops the outbound head; uca_grant while empty is ignored.
REQ-026 Latency: accepted bcp_uc appears on eng2uca 1 cycle later if the FIFO was empty; accepted broadcast appears on uc_out 1 cycle later.
REQ-027 Pointers wrap modulo depth; counts are ceil(log2(depth+1)) bits wide.
REQ-028 Entering HALT flushes both FIFOs in the same edge; in HALT, bcp_uc_ready=0, uc_out_valid=0, eng2uca_empty=1, and all inputs are ignored.

Reset
REQ-029 Reset clears both FIFOs, the seen table, drop_cnt and ovf_err, and sets state=RUN.
REQ-030 Output values during reset: eng2uca=0, eng2uca_valid=0, eng2uca_empty=1, uca2eng_full=0, bcp_uc_ready=1 after deassert, uc_out_valid=0, uc_out=0.
REQ-031 Reset asserted mid-transfer discards in-flight literals; no partial pops.

Structure
REQ-032 Shared package uc_pkg holds LIT_W=$clog2(LIT_IDX_MAX)+1, IN_DEPTH, OUT_DEPTH, the state enum and the lit_abs/lit_sign functions.
REQ-033 One sub-module uc_fifo (parameterised depth/width, push/pop/full/empty/head) is instantiated twice.

Verification
REQ-034 Broadcasts +3, -5 with uc_out_ready=0 -> uc_out=+3 from cycle 1 and in_count=2; raising uc_out_ready pops +3 then -5.
REQ-035 Five back-to-back broadcasts, uc_out_ready=0 -> full=1 after the 4th; the 5th is dropped and ovf_err=1.
REQ-036 Broadcast +7, then bcp_uc=+7 -> dropped, drop_cnt=1, eng2uca_empty stays 1; bcp_uc=-7 -> eng2uca=-7.
REQ-037 Broadcast +9 and bcp_uc=+9 in the same cycle -> bcp_uc dropped (bypass), drop_cnt=1.
REQ-038 Outbound holds 2 entries, conflict=1 -> next cycle eng2uca_empty=1 and bcp_uc_ready=0; the block stays in HALT until rst=0.
REQ-039 Fill the outbound FIFO with 4, grant 1 while bcp_uc_valid -> bcp_uc_ready=0 that cycle, then 1 the next; FIFO order is preserved across pointer wrap.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared widths, depths, state codes and literal helpers for the unit-clause engine port.
package uc_pkg;
  localparam int LIT_IDX_MAX = 64;
  localparam int LIT_W       = $clog2(LIT_IDX_MAX) + 1;
  localparam int IN_DEPTH    = 4;
  localparam int OUT_DEPTH   = 4;
  localparam int IN_CW       = $clog2(IN_DEPTH + 1);
  localparam int OUT_CW      = $clog2(OUT_DEPTH + 1);

  typedef logic [0:0] uc_state_t;
  localparam uc_state_t ST_RUN  = 1'b0;
  localparam uc_state_t ST_HALT = 1'b1;

  // Magnitude of a two's-complement literal; the most negative value maps to LIT_IDX_MAX.
  function automatic logic [LIT_W-1:0] lit_abs(input logic [LIT_W-1:0] l);
    return l[LIT_W-1] ? (~l + 1'b1) : l;
  endfunction

  function automatic logic lit_sign(input logic [LIT_W-1:0] l);
    return l[LIT_W-1];
  endfunction
endpackage

// File: rtl/uc_fifo.sv
// Small circular FIFO with registered occupancy count and a synchronous flush.
module uc_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk)
    if (do_push && !flush) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/uc_eng_port.sv
// Per-engine unit-clause port: inbound broadcast FIFO, outbound discovered-UC FIFO with
// duplicate suppression against previously broadcast literals, and a conflict halt.
module uc_eng_port
  import uc_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [LIT_W-1:0] uca2eng,
  input  logic                    uca2eng_valid,
  output logic                    uca2eng_full,
  output logic signed [LIT_W-1:0] eng2uca,
  output logic                    eng2uca_valid,
  output logic                    eng2uca_empty,
  input  logic                    uca_grant,
  input  logic                    conflict,
  input  logic                    bcp_uc_valid,
  input  logic signed [LIT_W-1:0] bcp_uc,
  output logic                    bcp_uc_ready,
  output logic                    uc_out_valid,
  output logic signed [LIT_W-1:0] uc_out,
  input  logic                    uc_out_ready,
  output logic [7:0]              drop_cnt,
  output logic                    ovf_err
);
  uc_state_t                   state;
  logic                        run, flush;
  logic [IN_CW-1:0]            in_count;
  logic [OUT_CW-1:0]           out_count;
  logic [LIT_W-1:0]            in_head, out_head;
  logic                        in_push, in_pop, out_push, out_pop, out_full, out_empty;
  logic                        bcp_acc, bcp_dup;
  logic [LIT_IDX_MAX:0][1:0]   seen;

  assign run   = (state == ST_RUN);
  assign flush = run && conflict;

  assign uca2eng_full = (in_count == IN_CW'(IN_DEPTH));
  assign in_push      = run && uca2eng_valid && (uca2eng != '0) && !uca2eng_full;
  assign uc_out_valid = run && (in_count != '0);
  assign uc_out       = uc_out_valid ? in_head : '0;
  assign in_pop       = uc_out_valid && uc_out_ready;

  assign out_full      = (out_count == OUT_CW'(OUT_DEPTH));
  assign out_empty     = (out_count == '0);
  assign bcp_uc_ready  = run && !out_full;
  assign bcp_acc       = bcp_uc_valid && bcp_uc_ready && (bcp_uc != '0);
  // Same-cycle broadcast is compared directly since the seen table updates one edge late.
  assign bcp_dup       = seen[lit_abs(bcp_uc)][lit_sign(bcp_uc)] || (in_push && (uca2eng == bcp_uc));
  assign out_push      = bcp_acc && !bcp_dup;
  assign out_pop       = run && uca_grant && !out_empty;
  assign eng2uca_empty = !run || out_empty;
  assign eng2uca_valid = !eng2uca_empty;
  assign eng2uca       = eng2uca_empty ? '0 : out_head;

  uc_fifo #(.DEPTH(IN_DEPTH), .W(LIT_W)) u_in (
    .clk(clk), .rst(rst), .flush(flush), .push(in_push), .pop(in_pop),
    .din(uca2eng), .head(in_head), .count(in_count)
  );

  uc_fifo #(.DEPTH(OUT_DEPTH), .W(LIT_W)) u_out (
    .clk(clk), .rst(rst), .flush(flush), .push(out_push), .pop(out_pop),
    .din(bcp_uc), .head(out_head), .count(out_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      seen     <= '0;
      drop_cnt <= '0;
      ovf_err  <= 1'b0;
    end else begin
      if (flush) state <= ST_HALT;
      if (in_push) seen[lit_abs(uca2eng)][lit_sign(uca2eng)] <= 1'b1;
      if (run && uca2eng_valid && uca2eng_full) ovf_err <= 1'b1;
      if (bcp_acc && bcp_dup && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_uc_eng_port.sv
// Bench for uc_eng_port: directed vector table, then random traffic against a queue-based model.
module tb_uc_eng_port;
  import uc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic signed [LIT_W-1:0] uca2eng, eng2uca, bcp_uc, uc_out;
  logic uca2eng_valid, uca2eng_full, eng2uca_valid, eng2uca_empty, uca_grant, conflict;
  logic bcp_uc_valid, bcp_uc_ready, uc_out_valid, uc_out_ready, ovf_err;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  uc_eng_port dut (
    .clk(clk), .rst(rst), .uca2eng(uca2eng), .uca2eng_valid(uca2eng_valid),
    .uca2eng_full(uca2eng_full), .eng2uca(eng2uca), .eng2uca_valid(eng2uca_valid),
    .eng2uca_empty(eng2uca_empty), .uca_grant(uca_grant), .conflict(conflict),
    .bcp_uc_valid(bcp_uc_valid), .bcp_uc(bcp_uc), .bcp_uc_ready(bcp_uc_ready),
    .uc_out_valid(uc_out_valid), .uc_out(uc_out), .uc_out_ready(uc_out_ready),
    .drop_cnt(drop_cnt), .ovf_err(ovf_err)
  );

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: plain queues and a seen bitmap.
  int inq[$], outq[$];
  bit seen_m[0:LIT_IDX_MAX][0:1];
  int mdrop;
  bit movf, mhalt;

  task automatic model_reset();
    inq.delete();
    outq.delete();
    for (int i = 0; i <= LIT_IDX_MAX; i++) begin
      seen_m[i][0] = 1'b0;
      seen_m[i][1] = 1'b0;
    end
    mdrop = 0;
    movf  = 1'b0;
    mhalt = 1'b0;
  endtask

  task automatic model_step();
    int b, c, ab, ac;
    bit ifull, ipush, ipop, acc, dup, opop;
    if (mhalt) return;
    b = uca2eng;
    c = bcp_uc;
    ab = (b < 0) ? -b : b;
    ac = (c < 0) ? -c : c;
    ifull = (inq.size() == IN_DEPTH);
    if (uca2eng_valid && ifull) movf = 1'b1;
    ipush = uca2eng_valid && (b != 0) && !ifull;
    ipop  = (inq.size() > 0) && uc_out_ready;
    acc   = bcp_uc_valid && (outq.size() < OUT_DEPTH) && (c != 0);
    dup   = seen_m[ac][c < 0] || (ipush && (b == c));
    opop  = uca_grant && (outq.size() > 0);
    if (acc && dup && mdrop < 255) mdrop++;
    if (ipush) seen_m[ab][b < 0] = 1'b1;
    if (conflict) begin
      inq.delete();
      outq.delete();
      mhalt = 1'b1;
    end else begin
      if (ipop) void'(inq.pop_front());
      if (ipush) inq.push_back(b);
      if (opop) void'(outq.pop_front());
      if (acc && !dup) outq.push_back(c);
    end
  endtask

  task automatic check_model();
    bit ee;
    ee = mhalt || (outq.size() == 0);
    chk("m_uc_out_valid", uc_out_valid, (!mhalt && inq.size() > 0));
    chk("m_uc_out", uc_out, (inq.size() > 0) ? inq[0] : 0);
    chk("m_full", uca2eng_full, (inq.size() == IN_DEPTH));
    chk("m_eng_empty", eng2uca_empty, ee);
    chk("m_eng_valid", eng2uca_valid, !ee);
    chk("m_eng2uca", eng2uca, ee ? 0 : outq[0]);
    chk("m_bcp_ready", bcp_uc_ready, (!mhalt && outq.size() < OUT_DEPTH));
    chk("m_drop_cnt", drop_cnt, mdrop);
    chk("m_ovf_err", ovf_err, movf);
  endtask

  task automatic drive(input bit bv, input int b, input bit rdy, input bit cv, input int c,
                       input bit gr, input bit cf);
    uca2eng_valid = bv;
    uca2eng       = LIT_W'(b);
    uc_out_ready  = rdy;
    bcp_uc_valid  = cv;
    bcp_uc        = LIT_W'(c);
    uca_grant     = gr;
    conflict      = cf;
  endtask

  task automatic cycle(input bit bv, input int b, input bit rdy, input bit cv, input int c,
                       input bit gr, input bit cf);
    drive(bv, b, rdy, cv, c, gr, cf);
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  // Asserts reset with random inputs applied, checks reset outputs, releases on a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    drive($urandom_range(0, 1), $urandom_range(0, 20) - 10, 1'b1, $urandom_range(0, 1),
          $urandom_range(0, 20) - 10, 1'b1, 1'b0);
    #2;
    chk("rst_eng2uca", eng2uca, 0);
    chk("rst_eng_valid", eng2uca_valid, 0);
    chk("rst_eng_empty", eng2uca_empty, 1);
    chk("rst_full", uca2eng_full, 0);
    chk("rst_uc_out_valid", uc_out_valid, 0);
    chk("rst_uc_out", uc_out, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_ovf_err", ovf_err, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    bit bv; int b; bit rdy; bit cv; int c; bit gr; bit cf;
    bit uov; int uo; bit full; bit ee; int eng; int drop; bit ovf; bit brdy;
  } vec_t;

  function automatic vec_t mk(bit bv, int b, bit rdy, bit cv, int c, bit gr, bit cf,
                              bit uov, int uo, bit full, bit ee, int eng, int drop,
                              bit ovf, bit brdy);
    vec_t v;
    v.bv = bv; v.b = b; v.rdy = rdy; v.cv = cv; v.c = c; v.gr = gr; v.cf = cf;
    v.uov = uov; v.uo = uo; v.full = full; v.ee = ee; v.eng = eng; v.drop = drop;
    v.ovf = ovf; v.brdy = brdy;
    return v;
  endfunction

  vec_t tbl[$];
  int halt_cycles;

  initial begin
    //                 bv  b   rdy cv  c   gr cf  uov uo  full ee eng drop ovf brdy
    tbl.push_back(mk(1,  3, 0, 0,  0, 0, 0,  1,  3, 0, 1,  0, 0, 0, 1));
    tbl.push_back(mk(1, -5, 0, 0,  0, 0, 0,  1,  3, 0, 1,  0, 0, 0, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 0,  1, -5, 0, 1,  0, 0, 0, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 0,  0,  0, 0, 1,  0, 0, 0, 1));
    tbl.push_back(mk(1, 11, 0, 0,  0, 0, 0,  1, 11, 0, 1,  0, 0, 0, 1));
    tbl.push_back(mk(1, 12, 0, 0,  0, 0, 0,  1, 11, 0, 1,  0, 0, 0, 1));
    tbl.push_back(mk(1, 13, 0, 0,  0, 0, 0,  1, 11, 0, 1,  0, 0, 0, 1));
    tbl.push_back(mk(1, 14, 0, 0,  0, 0, 0,  1, 11, 1, 1,  0, 0, 0, 1));
    tbl.push_back(mk(1, 15, 0, 0,  0, 0, 0,  1, 11, 1, 1,  0, 0, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 0,  1, 12, 0, 1,  0, 0, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 0,  1, 13, 0, 1,  0, 0, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 0,  1, 14, 0, 1,  0, 0, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 0,  0,  0, 0, 1,  0, 0, 1, 1));
    tbl.push_back(mk(1,  7, 1, 0,  0, 0, 0,  1,  7, 0, 1,  0, 0, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1,  7, 0, 0,  0,  0, 0, 1,  0, 1, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1, -7, 0, 0,  0,  0, 0, 0, -7, 1, 1, 1));
    tbl.push_back(mk(1,  9, 1, 1,  9, 1, 0,  1,  9, 0, 1,  0, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 0,  0,  0, 0, 1,  0, 2, 1, 1));
    tbl.push_back(mk(1,  0, 1, 1,  0, 0, 0,  0,  0, 0, 1,  0, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 1, 0,  0,  0, 0, 1,  0, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1, 20, 0, 0,  0,  0, 0, 0, 20, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1, 21, 0, 0,  0,  0, 0, 0, 20, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1, 22, 0, 0,  0,  0, 0, 0, 20, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1, 23, 0, 0,  0,  0, 0, 0, 20, 2, 1, 0));
    tbl.push_back(mk(0,  0, 1, 1, 24, 1, 0,  0,  0, 0, 0, 21, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1, 24, 1, 0,  0,  0, 0, 0, 22, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 1, 0,  0,  0, 0, 0, 23, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 1, 0,  0,  0, 0, 0, 24, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 1, 0,  0,  0, 0, 1,  0, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1, 30, 0, 0,  0,  0, 0, 0, 30, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 1, 31, 0, 0,  0,  0, 0, 0, 30, 2, 1, 1));
    tbl.push_back(mk(0,  0, 1, 0,  0, 0, 1,  0,  0, 0, 1,  0, 2, 1, 0));
    tbl.push_back(mk(1, 40, 1, 1, 41, 1, 0,  0,  0, 0, 1,  0, 2, 1, 0));

    do_reset();
    chk("post_rst_bcp_ready", bcp_uc_ready, 1);

    foreach (tbl[i]) begin
      cycle(tbl[i].bv, tbl[i].b, tbl[i].rdy, tbl[i].cv, tbl[i].c, tbl[i].gr, tbl[i].cf);
      chk($sformatf("v%0d_uc_out_valid", i), uc_out_valid, tbl[i].uov);
      chk($sformatf("v%0d_uc_out", i), uc_out, tbl[i].uo);
      chk($sformatf("v%0d_full", i), uca2eng_full, tbl[i].full);
      chk($sformatf("v%0d_eng_empty", i), eng2uca_empty, tbl[i].ee);
      chk($sformatf("v%0d_eng_valid", i), eng2uca_valid, !tbl[i].ee);
      chk($sformatf("v%0d_eng2uca", i), eng2uca, tbl[i].eng);
      chk($sformatf("v%0d_drop_cnt", i), drop_cnt, tbl[i].drop);
      chk($sformatf("v%0d_ovf_err", i), ovf_err, tbl[i].ovf);
      chk($sformatf("v%0d_bcp_ready", i), bcp_uc_ready, tbl[i].brdy);
      if (i == 1) chk("v1_in_count", int'(dut.in_count), 2);
    end

    // HALT persists with traffic applied until reset.
    repeat (4) begin
      cycle(1, 5, 1, 1, 6, 1, 0);
      chk("halt_eng_empty", eng2uca_empty, 1);
      chk("halt_bcp_ready", bcp_uc_ready, 0);
    end

    // Reset while both FIFOs hold data discards everything.
    do_reset();
    cycle(1, 2, 0, 1, 3, 0, 0);
    cycle(1, 4, 0, 1, 5, 0, 0);
    do_reset();
    chk("rst_mid_in_count", int'(dut.in_count), 0);

    halt_cycles = 0;
    for (int n = 0; n < 4000; n++) begin
      if (halt_cycles > 6 || $urandom_range(0, 499) == 0) begin
        do_reset();
        halt_cycles = 0;
      end
      cycle($urandom_range(0, 1), int'($urandom_range(0, 24)) - 12, $urandom_range(0, 3) == 0,
            $urandom_range(0, 1), int'($urandom_range(0, 24)) - 12, $urandom_range(0, 2) == 0,
            $urandom_range(0, 299) == 0);
      if (mhalt) halt_cycles++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
